// File: rtl/mult_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding,
// iteration/latency constants and the operand magnitude helper.
package mult_seq_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_ITER    = MULT_WIDTH;
  localparam int MULT_LATENCY = MULT_ITER + 2;
  localparam int MULT_CNT_W   = $clog2(MULT_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Magnitude of an operand; unsigned operands pass through untouched.
  // The most negative value maps to 2^(W-1), which is exact as an unsigned number.
  function automatic logic [MULT_WIDTH-1:0] mult_mag(
    input logic [MULT_WIDTH-1:0] v,
    input logic                  is_signed
  );
    return (is_signed && v[MULT_WIDTH-1]) ? (~v + MULT_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Start/busy/done handshake and operand/result bundle between the control
// unit (master) and the multiplier (slave).
interface mult_seq_if
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 overflow;

  modport master (
    output start, signed_op, x, y,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, signed_op, x, y,
    output busy, done, product, overflow
  );

endinterface

// File: rtl/mult_add33.sv
// Combinational W+1-bit adder used for the one partial-sum addition per cycle.
module mult_add33 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   s
);

  assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq.sv
// Iterative WIDTH x WIDTH shift-add multiplier: magnitudes multiplied over
// MULT_ITER cycles, then sign fix-up and overflow in a separate FIX cycle.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t          state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [WIDTH-1:0]     mcand_q,    mcand_d;
  logic [WIDTH-1:0]     hi_q,       hi_d;
  logic [WIDTH-1:0]     lo_q,       lo_d;
  logic                 neg_q,      neg_d;
  logic                 signed_q,   signed_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic [2*WIDTH-1:0]   product_q,  product_d;
  logic                 overflow_q, overflow_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum33;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   fixed;
  logic                 fixed_ovf;

  assign addend = lo_q[0] ? mcand_q : '0;

  mult_add33 #(.W(WIDTH)) u_add (
    .a (hi_q),
    .b (addend),
    .s (sum33)
  );

  // The negate lives only on the FIX path, so it never chains with the add.
  assign acc   = {hi_q, lo_q};
  assign fixed = neg_q ? (~acc + (2*WIDTH)'(1)) : acc;
  assign fixed_ovf = signed_q ? (fixed[2*WIDTH-1:WIDTH] != {WIDTH{fixed[WIDTH-1]}})
                              : (fixed[2*WIDTH-1:WIDTH] != '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_d      = neg_q;
    signed_d   = signed_q;
    product_d  = product_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d    = mult_mag(bus.x, bus.signed_op);
          lo_d       = mult_mag(bus.y, bus.signed_op);
          neg_d      = bus.signed_op & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
          signed_d   = bus.signed_op;
          hi_d       = '0;
          cnt_d      = '0;
          product_d  = '0;
          overflow_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        // Shift {carry,hi,lo} right by one; the carry lands in hi's MSB.
        hi_d  = sum33[WIDTH:1];
        lo_d  = {sum33[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        {hi_d, lo_d} = fixed;
        product_d    = fixed;
        overflow_d   = fixed_ovf;
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_q      <= 1'b0;
      signed_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_q      <= neg_d;
      signed_q   <= signed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.product  = product_q;
  assign bus.overflow = overflow_q;

endmodule
